// File: rtl/report_pkt_tx.sv
// report_pkt_tx: commit/rewind packet store feeding the downstream mux over req/ack; REPORT_TX_STAT_EN adds event counters
module report_pkt_tx #(
  parameter int DEPTH = 256,
  parameter int MAX_PKT_WORDS = 32,
  parameter int AW = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [133:0] iv_data,
  input  logic         i_data_wr,
  output logic         o_data_lcm_req,
  input  logic         i_data_lcm_ack,
  output logic [133:0] ov_data_lcm,
  output logic         o_pkt_drop,
`ifdef REPORT_TX_STAT_EN
  output logic         o_fmt_err,
  output logic [15:0]  ov_tx_pkt_cnt,
  output logic [15:0]  ov_drop_cnt,
  output logic [15:0]  ov_err_cnt
`else
  output logic         o_fmt_err
`endif
);
  localparam int WCW = $clog2(MAX_PKT_WORDS) + 1;
  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DROP} wr_st_t;
  typedef enum logic [1:0] {RD_IDLE, RD_REQ, RD_SEND} rd_st_t;
  wr_st_t ws;
  rd_st_t rs;
  ptr_t wr_ptr, cm_ptr, rd_ptr, fp, pkt_cnt, free;
  logic [WCW-1:0] wcnt;
  logic [133:0] mem [DEPTH];
  logic [133:0] rdata;
  logic [AW-1:0] wa, ra;
  logic hd, tl, in_pkt, over, space_ok, we, drop, err, commit, done;
  // word classification, space check against the committed pointer, write/read addressing
  always_comb begin
    hd = i_data_wr && iv_data[133:132] == 2'b01;
    tl = i_data_wr && iv_data[133:132] == 2'b10;
    in_pkt = i_data_wr && ws == WR_PKT && !hd;
    over = wcnt == WCW'(MAX_PKT_WORDS - 1);
    free = ptr_t'(DEPTH) - (cm_ptr - rd_ptr);
    space_ok = free >= ptr_t'(MAX_PKT_WORDS);
    we = (hd && space_ok) || (in_pkt && (tl || !over));
    wa = hd ? cm_ptr[AW-1:0] : wr_ptr[AW-1:0];
    drop = (hd && !space_ok) || (in_pkt && !tl && over);
    err = (hd && ws == WR_PKT) || (i_data_wr && ws == WR_IDLE && !hd);
    commit = in_pkt && tl;
    done = rs == RD_SEND && ov_data_lcm[133:132] == 2'b10;
    ra = rs == RD_SEND ? fp[AW-1:0] : rd_ptr[AW-1:0] + AW'(rs == RD_REQ && i_data_lcm_ack);
  end
  // write FSM: a head always restarts at the committed pointer, a tail commits, overruns rewind
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ws <= WR_IDLE;
      wr_ptr <= '0;
      cm_ptr <= '0;
      wcnt <= '0;
      o_pkt_drop <= 1'b0;
      o_fmt_err <= 1'b0;
    end else begin
      o_pkt_drop <= drop;
      o_fmt_err <= err;
      if (hd) begin
        wr_ptr <= space_ok ? cm_ptr + ptr_t'(1) : cm_ptr;
        wcnt <= WCW'(1);
        ws <= space_ok ? WR_PKT : WR_DROP;
      end else if (in_pkt) begin
        if (tl) begin
          wr_ptr <= wr_ptr + ptr_t'(1);
          cm_ptr <= wr_ptr + ptr_t'(1);
          ws <= WR_IDLE;
        end else if (over) begin
          wr_ptr <= cm_ptr;
          ws <= WR_DROP;
        end else begin
          wr_ptr <= wr_ptr + ptr_t'(1);
          wcnt <= wcnt + WCW'(1);
        end
      end else if (tl && ws == WR_DROP) ws <= WR_IDLE;
    end
  end
  // read FSM: request, wait for ack, then stream the prefetched words back to back
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rs <= RD_IDLE;
      rd_ptr <= '0;
      fp <= '0;
      pkt_cnt <= '0;
      o_data_lcm_req <= 1'b0;
      ov_data_lcm <= '0;
    end else begin
      pkt_cnt <= pkt_cnt + ptr_t'(commit) - ptr_t'(done);
      case (rs)
        RD_IDLE: if (pkt_cnt != '0) begin
          o_data_lcm_req <= 1'b1;
          rs <= RD_REQ;
        end
        RD_REQ: if (i_data_lcm_ack) begin
          o_data_lcm_req <= 1'b0;
          ov_data_lcm <= rdata;
          fp <= rd_ptr + ptr_t'(2);
          rs <= RD_SEND;
        end
        RD_SEND: if (done) begin
          ov_data_lcm <= '0;
          rd_ptr <= fp - ptr_t'(1);
          rs <= RD_IDLE;
        end else begin
          ov_data_lcm <= rdata;
          fp <= fp + ptr_t'(1);
        end
        default: rs <= RD_IDLE;
      endcase
    end
  end
  // packet store with registered read port
  always_ff @(posedge i_clk) begin
    if (we) mem[wa] <= iv_data;
    rdata <= mem[ra];
  end
`ifdef REPORT_TX_STAT_EN
  // wrapping event counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ov_tx_pkt_cnt <= '0;
      ov_drop_cnt <= '0;
      ov_err_cnt <= '0;
    end else begin
      ov_tx_pkt_cnt <= ov_tx_pkt_cnt + 16'(done);
      ov_drop_cnt <= ov_drop_cnt + 16'(drop);
      ov_err_cnt <= ov_err_cnt + 16'(err);
    end
  end
`endif
endmodule

// File: tb/tb_report_pkt_tx.sv
// tb_report_pkt_tx: scoreboard bench for report_pkt_tx
module tb_report_pkt_tx;
  logic i_clk = 0, i_rst = 1, i_data_wr = 0, i_data_lcm_ack = 0;
  logic [133:0] iv_data = '0;
  logic o_data_lcm_req, o_pkt_drop, o_fmt_err;
  logic [133:0] ov_data_lcm;
`ifdef REPORT_TX_STAT_EN
  logic [15:0] ov_tx_pkt_cnt, ov_drop_cnt, ov_err_cnt;
`endif
  int n_chk = 0, n_fail = 0, rx = 0, n_drop = 0, n_err = 0, exp_drop = 0, exp_err = 0;
  bit ack_en = 1;
  logic [133:0] q [$];
  report_pkt_tx #(.DEPTH(64), .MAX_PKT_WORDS(32), .AW(6)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .iv_data(iv_data), .i_data_wr(i_data_wr),
    .o_data_lcm_req(o_data_lcm_req), .i_data_lcm_ack(i_data_lcm_ack),
    .ov_data_lcm(ov_data_lcm), .o_pkt_drop(o_pkt_drop),
`ifdef REPORT_TX_STAT_EN
    .o_fmt_err(o_fmt_err), .ov_tx_pkt_cnt(ov_tx_pkt_cnt), .ov_drop_cnt(ov_drop_cnt), .ov_err_cnt(ov_err_cnt)
`else
    .o_fmt_err(o_fmt_err)
`endif
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [134:0] got, input logic [134:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [1:0] f, input bit keep);
    logic [133:0] w;
    w = {f, 4'h0, $urandom, $urandom, $urandom, $urandom};
    @(negedge i_clk);
    iv_data = w;
    i_data_wr = 1;
    if (keep) q.push_back(w);
  endtask
  task automatic idle();
    @(negedge i_clk);
    i_data_wr = 0;
    iv_data = '0;
  endtask
  task automatic send_pkt(input int n, input bit keep);
    put(2'b01, keep);
    for (int i = 1; i < n - 1; i++) put(2'b11, keep);
    put(2'b10, keep);
  endtask
  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || o_data_lcm_req || ov_data_lcm != '0) && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    repeat (3) @(negedge i_clk);
    chk("drain", 135'(q.size()), 135'(0));
    chk("drop_cnt", 135'(n_drop), 135'(exp_drop));
    chk("err_cnt", 135'(n_err), 135'(exp_err));
  endtask
  // ack responder: one-cycle ack two cycles after req rises
  initial forever begin
    @(negedge i_clk);
    if (o_data_lcm_req && ack_en && !i_rst) begin
      @(negedge i_clk);
      chk("req_hold", 135'(o_data_lcm_req), 135'(1));
      i_data_lcm_ack = 1;
      @(negedge i_clk);
      i_data_lcm_ack = 0;
      chk("req_drop", 135'(o_data_lcm_req), 135'(0));
      chk("first_head", 135'(ov_data_lcm[133:132]), 135'(2'b01));
    end
  end
  // output monitor: scoreboard pop, contiguity, post-tail idle, pulse counting
  initial begin
    bit in_pkt, prev_tail;
    in_pkt = 0;
    prev_tail = 0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        in_pkt = 0;
        prev_tail = 0;
      end else begin
        if (o_pkt_drop) n_drop++;
        if (o_fmt_err) n_err++;
        if (prev_tail) chk("post_tail", {o_data_lcm_req, ov_data_lcm}, '0);
        else if (in_pkt) chk("gap", 135'(ov_data_lcm != '0), 135'(1));
        if (ov_data_lcm != '0) begin
          rx++;
          chk("req_busy", 135'(o_data_lcm_req), 135'(0));
          if (q.size() == 0) chk("extra_word", 135'(ov_data_lcm), 135'(0));
          else chk("word", 135'(ov_data_lcm), 135'(q.pop_front()));
        end
        prev_tail = ov_data_lcm[133:132] == 2'b10;
        in_pkt = ov_data_lcm != '0 && !prev_tail;
      end
    end
  end
  initial begin
    int base, t;
    repeat (3) @(negedge i_clk);
    chk("rst_out", {o_data_lcm_req, ov_data_lcm}, '0);
    chk("rst_pulse", 135'({o_pkt_drop, o_fmt_err}), 135'(0));
    i_rst = 0;
    @(negedge i_clk);
    // single 4-word packet, req timing relative to commit
    send_pkt(4, 1);
    idle();
    chk("req_early", 135'(o_data_lcm_req), 135'(0));
    @(negedge i_clk);
    chk("req_rise", 135'(o_data_lcm_req), 135'(1));
    wait_drain();
    // back-to-back 3-word packets
    base = rx;
    send_pkt(3, 1);
    send_pkt(3, 1);
    idle();
    wait_drain();
    chk("b2b_words", 135'(rx - base), 135'(6));
    // ack withheld, third 20-word packet lacks space
    ack_en = 0;
    base = rx;
    send_pkt(20, 1);
    send_pkt(20, 1);
    send_pkt(20, 0);
    exp_drop++;
    idle();
    repeat (5) @(negedge i_clk);
    chk("held_req", 135'(o_data_lcm_req), 135'(1));
    chk("held_none", 135'(rx - base), 135'(0));
    ack_en = 1;
    wait_drain();
    chk("full_words", 135'(rx - base), 135'(40));
    // head arriving mid-packet rewinds the first packet
    base = rx;
    put(2'b01, 0);
    put(2'b11, 0);
    exp_err++;
    send_pkt(3, 1);
    idle();
    wait_drain();
    chk("rewind_words", 135'(rx - base), 135'(3));
    // stray body word and overlong packet
    base = rx;
    put(2'b11, 0);
    exp_err++;
    idle();
    repeat (4) @(negedge i_clk);
    chk("stray_req", 135'(o_data_lcm_req), 135'(0));
    send_pkt(33, 0);
    exp_drop++;
    idle();
    repeat (6) @(negedge i_clk);
    chk("long_req", 135'(o_data_lcm_req), 135'(0));
    wait_drain();
    chk("bad_words", 135'(rx - base), 135'(0));
    // reset in the middle of an 8-word transmission
    base = rx;
    send_pkt(8, 1);
    idle();
    t = 0;
    while (rx - base < 3 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    chk("rst_reach", 135'(rx - base >= 3), 135'(1));
    i_rst = 1;
    @(negedge i_clk);
    chk("mid_rst_out", {o_data_lcm_req, ov_data_lcm}, '0);
`ifdef REPORT_TX_STAT_EN
    chk("mid_rst_stat", 135'({ov_tx_pkt_cnt, ov_drop_cnt, ov_err_cnt}), 135'(0));
`endif
    q.delete();
    n_drop = 0;
    n_err = 0;
    exp_drop = 0;
    exp_err = 0;
    @(negedge i_clk);
    i_rst = 0;
    repeat (4) @(negedge i_clk);
    chk("post_rst_req", 135'(o_data_lcm_req), 135'(0));
    base = rx;
    send_pkt(5, 1);
    idle();
    wait_drain();
    chk("post_rst_words", 135'(rx - base), 135'(5));
`ifdef REPORT_TX_STAT_EN
    chk("stat_tx", 135'(ov_tx_pkt_cnt), 135'(1));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
